// File: rtl/wb_stage.sv
// wb_stage: writeback arbiter merging MEM/WB entries (via a 2-entry FIFO) and long-latency unit results onto one regfile write port.
// Latency: LU result is registered on its accept edge; a MEM entry enqueued into an empty FIFO is written one edge later.
// Backpressure: mw_ready drops only while the FIFO holds 2 entries; lu_ready drops only when fairness forces the FIFO.
// Optional feature macro: WB_FAIR_EN adds a 2-bit starvation counter that forces the FIFO head after 3 consecutive LU wins.

// wb_fifo: 2-entry FIFO with registered count and 1-bit wrapping pointers.
// Latency: pushed data is visible at head_dat the cycle after the push edge.
// Backpressure: caller must not push when count==2 nor pop when count==0; such requests are ignored.
module wb_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push  = push_vld && (count != 2'd2);
    assign do_pop   = pop_vld && (count != 2'd0);
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; a push and pop on the same edge leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        mw_valid,
    input  logic        mw_reg_write_en,
    input  logic        mw_mem_to_reg,
    input  logic [3:0]  mw_rd,
    input  logic [31:0] mw_alu_result,
    input  logic [31:0] mw_mem_data,
    output logic        mw_ready,
    input  logic        lu_valid,
    input  logic [3:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        reg_write_en_wb,
    output logic [3:0]  write_reg_addr_wb,
    output logic [31:0] write_data_wb,
    output logic [15:0] wb_count
);
    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] dat;
    } wb_ent_t;

    wb_ent_t    push_ent;
    wb_ent_t    head_ent;
    logic [1:0] fifo_count;
    logic       fifo_nonempty;
    logic       push_vld;
    logic       force_fifo;
    logic       lu_grant;
    logic       fifo_grant;

    // Data selection happens at enqueue so the FIFO only stores what will be written.
    assign push_ent.rd  = mw_rd;
    assign push_ent.dat = mw_mem_to_reg ? mw_mem_data : mw_alu_result;

    // Non-writing entries (stores, compares, branches) are accepted and dropped.
    assign mw_ready      = (fifo_count != 2'd2);
    assign push_vld      = mw_valid && mw_ready && mw_reg_write_en;
    assign fifo_nonempty = (fifo_count != 2'd0);

    wb_fifo #(.W($bits(wb_ent_t))) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_ent),
        .pop_vld  (fifo_grant),
        .head_dat (head_ent),
        .count    (fifo_count)
    );

`ifdef WB_FAIR_EN
    logic [1:0] starve_cnt;

    assign force_fifo = (starve_cnt == 2'd3) && fifo_nonempty;

    // Count LU wins while the FIFO waits; cleared whenever the FIFO gets the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 2'd0;
        end else if (fifo_grant) begin
            starve_cnt <= 2'd0;
        end else if (lu_grant && fifo_nonempty) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end
`else
    assign force_fifo = 1'b0;
`endif

    // LU has priority unless the FIFO is being forced; lu_ready never looks at FIFO occupancy otherwise.
    assign lu_ready   = !force_fifo;
    assign lu_grant   = lu_valid && !force_fifo;
    assign fifo_grant = fifo_nonempty && !lu_grant;

    // Register the granted write; address and data hold when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_en_wb   <= 1'b0;
            write_reg_addr_wb <= 4'd0;
            write_data_wb     <= 32'd0;
            wb_count          <= 16'd0;
        end else begin
            reg_write_en_wb <= lu_grant || fifo_grant;
            if (lu_grant) begin
                write_reg_addr_wb <= lu_rd;
                write_data_wb     <= lu_data;
            end else if (fifo_grant) begin
                write_reg_addr_wb <= head_ent.rd;
                write_data_wb     <= head_ent.dat;
            end
            if (lu_grant || fifo_grant) wb_count <= wb_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed stimulus against a queue-based writeback model.
// Latency: model predicts registered outputs one edge after the inputs it consumes.
// Backpressure: model acceptance follows FIFO occupancy and the fairness rule.
module tb_wb_stage;
`ifdef WB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mw_valid, mw_reg_write_en, mw_mem_to_reg;
    logic [3:0]  mw_rd;
    logic [31:0] mw_alu_result, mw_mem_data;
    logic        mw_ready;
    logic        lu_valid;
    logic [3:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        reg_write_en_wb;
    logic [3:0]  write_reg_addr_wb;
    logic [31:0] write_data_wb;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .mw_valid          (mw_valid),
        .mw_reg_write_en   (mw_reg_write_en),
        .mw_mem_to_reg     (mw_mem_to_reg),
        .mw_rd             (mw_rd),
        .mw_alu_result     (mw_alu_result),
        .mw_mem_data       (mw_mem_data),
        .mw_ready          (mw_ready),
        .lu_valid          (lu_valid),
        .lu_rd             (lu_rd),
        .lu_data           (lu_data),
        .lu_ready          (lu_ready),
        .reg_write_en_wb   (reg_write_en_wb),
        .write_reg_addr_wb (write_reg_addr_wb),
        .write_data_wb     (write_data_wb),
        .wb_count          (wb_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes as a queue, last registered write, count, LU-win streak.
    typedef struct {
        logic [3:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        m_q[$];
    logic        m_en;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_cnt;
    int          m_starve;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_lu_ready();
        return !(FAIR && (m_starve >= 3) && (m_q.size() > 0));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_en     = 1'b0;
        m_addr   = 4'd0;
        m_data   = 32'd0;
        m_cnt    = 16'd0;
        m_starve = 0;
    endtask

    // Apply one clock edge to the model using the inputs held across that edge.
    task automatic model_update();
        int   sz;
        logic lu_win, fifo_win, acc;
        ent_t e;
        sz       = m_q.size();
        lu_win   = lu_valid && exp_lu_ready();
        fifo_win = (sz > 0) && !lu_win;
        acc      = mw_valid && (sz < 2) && mw_reg_write_en;
        m_en     = lu_win || fifo_win;
        if (lu_win) begin
            m_addr = lu_rd;
            m_data = lu_data;
        end else if (fifo_win) begin
            e      = m_q.pop_front();
            m_addr = e.rd;
            m_data = e.dat;
        end
        if (m_en) m_cnt = m_cnt + 16'd1;
        if (fifo_win) m_starve = 0;
        else if (lu_win && sz > 0) m_starve = m_starve + 1;
        if (acc) begin
            e.rd  = mw_rd;
            e.dat = mw_mem_to_reg ? mw_mem_data : mw_alu_result;
            m_q.push_back(e);
        end
    endtask

    // Per-cycle comparison of every output against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("mw_ready", {31'd0, mw_ready}, {31'd0, (m_q.size() != 2)});
            chk("lu_ready", {31'd0, lu_ready}, {31'd0, exp_lu_ready()});
            chk("wr_en", {31'd0, reg_write_en_wb}, {31'd0, m_en});
            chk("wr_addr", {28'd0, write_reg_addr_wb}, {28'd0, m_addr});
            chk("wr_data", write_data_wb, m_data);
            chk("wb_count", {16'd0, wb_count}, {16'd0, m_cnt});
        end
    end

    task automatic idle();
        mw_valid = 1'b0; mw_reg_write_en = 1'b0; mw_mem_to_reg = 1'b0;
        mw_rd = 4'd0; mw_alu_result = 32'd0; mw_mem_data = 32'd0;
        lu_valid = 1'b0; lu_rd = 4'd0; lu_data = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drive_mw(input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                            input logic mtr, input logic we);
        mw_valid = 1'b1; mw_reg_write_en = we; mw_mem_to_reg = mtr;
        mw_rd = rd; mw_alu_result = alu; mw_mem_data = mem;
    endtask

    task automatic rand_inputs(input int lu_pct, input int mw_pct);
        mw_valid        = ($urandom_range(0, 99) < mw_pct);
        mw_reg_write_en = ($urandom_range(0, 3) != 0);
        mw_mem_to_reg   = $urandom_range(0, 1);
        mw_rd           = 4'($urandom);
        mw_alu_result   = $urandom;
        mw_mem_data     = $urandom;
        lu_valid        = ($urandom_range(0, 99) < lu_pct);
        lu_rd           = 4'($urandom);
        lu_data         = $urandom;
    endtask

    initial begin
        idle();
        model_reset();
        reset = 1'b0;
        #12;
        chk("reset_en", {31'd0, reg_write_en_wb}, 32'd0);
        chk("reset_mw_ready", {31'd0, mw_ready}, 32'd1);
        release_reset();

        // Single ALU entry: written one edge after acceptance.
        drive_mw(4'd3, 32'h11, 32'h55, 1'b0, 1'b1);
        step();
        idle();
        step();
        chk("alu_en", {31'd0, reg_write_en_wb}, 32'd1);
        chk("alu_addr", {28'd0, write_reg_addr_wb}, 32'd3);
        chk("alu_data", write_data_wb, 32'h11);
        chk("alu_count", {16'd0, wb_count}, 32'd1);

        // Memory-data entry followed by a non-writing entry: exactly one write.
        assert_reset();
        release_reset();
        drive_mw(4'd5, 32'h1234, 32'hDEADBEEF, 1'b1, 1'b1);
        step();
        drive_mw(4'd7, 32'h77, 32'h88, 1'b0, 1'b0);
        step();
        chk("mem_addr", {28'd0, write_reg_addr_wb}, 32'd5);
        chk("mem_data", write_data_wb, 32'hDEADBEEF);
        idle();
        step();
        step();
        chk("mem_en_after", {31'd0, reg_write_en_wb}, 32'd0);
        chk("mem_count", {16'd0, wb_count}, 32'd1);

`ifdef WB_FAIR_EN
        // Fairness: after three LU wins with the FIFO waiting, the head is forced through.
        assert_reset();
        release_reset();
        lu_valid = 1'b1; lu_rd = 4'd1; lu_data = 32'h100;
        drive_mw(4'd8, 32'h80, 32'h0, 1'b0, 1'b1);
        step();
        mw_valid = 1'b0;
        repeat (3) step();
        chk("fair_lu_ready_low", {31'd0, lu_ready}, 32'd0);
        chk("fair_lu_addr", {28'd0, write_reg_addr_wb}, 32'd1);
        step();
        chk("fair_fifo_addr", {28'd0, write_reg_addr_wb}, 32'd8);
        chk("fair_fifo_data", write_data_wb, 32'h80);
        chk("fair_lu_ready_back", {31'd0, lu_ready}, 32'd1);
        step();
        chk("fair_lu_resume", {28'd0, write_reg_addr_wb}, 32'd1);
        idle();
`else
        // Strict LU priority: FIFO fills, then drains in order once LU goes quiet.
        assert_reset();
        release_reset();
        lu_valid = 1'b1; lu_rd = 4'd1; lu_data = 32'h100;
        drive_mw(4'd8, 32'h80, 32'h0, 1'b0, 1'b1);
        step();
        drive_mw(4'd9, 32'h90, 32'h0, 1'b0, 1'b1);
        step();
        drive_mw(4'd10, 32'hA0, 32'h0, 1'b0, 1'b1);
        chk("prio_full", {31'd0, mw_ready}, 32'd0);
        step();
        chk("prio_still_full", {31'd0, mw_ready}, 32'd0);
        chk("prio_lu_addr", {28'd0, write_reg_addr_wb}, 32'd1);
        lu_valid = 1'b0;
        step();
        chk("drain0", {28'd0, write_reg_addr_wb}, 32'd8);
        chk("drain0_data", write_data_wb, 32'h80);
        step();
        chk("drain1", {28'd0, write_reg_addr_wb}, 32'd9);
        mw_valid = 1'b0;
        step();
        chk("drain2", {28'd0, write_reg_addr_wb}, 32'd10);
        chk("drain_count", {16'd0, wb_count}, 32'd6);
        step();
        chk("drain_idle", {31'd0, reg_write_en_wb}, 32'd0);
`endif

        // Randomized traffic with varying LU pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                rand_inputs(ph * 30, 70);
                step();
            end
        end

        // Reset with FIFO full and a write pending; then count wraparound.
        idle();
        assert_reset();
        release_reset();
        lu_valid = 1'b1; lu_rd = 4'd2; lu_data = 32'h200;
        drive_mw(4'd11, 32'hB0, 32'h0, 1'b0, 1'b1);
        step();
        drive_mw(4'd12, 32'hC0, 32'h0, 1'b0, 1'b1);
        step();
        #2;
        assert_reset();
        chk("rst_en", {31'd0, reg_write_en_wb}, 32'd0);
        chk("rst_count", {16'd0, wb_count}, 32'd0);
        chk("rst_mw_ready", {31'd0, mw_ready}, 32'd1);
        release_reset();
        step();
        step();
        chk("no_stale_en", {31'd0, reg_write_en_wb}, 32'd0);
        chk("no_stale_count", {16'd0, wb_count}, 32'd0);
        lu_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            lu_rd   = 4'($urandom);
            lu_data = $urandom;
            step();
        end
        chk("count_max", {16'd0, wb_count}, 32'h0000FFFF);
        step();
        chk("count_wrap", {16'd0, wb_count}, 32'd0);
        idle();
        step();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
